stopwatch_bcd_counter: RTL and testbench

Downstream consumer of the 10 ms timer's o_base_tick. Owns the run/pause/clear control FSM and drives the timer's enable and clear inputs. Counts BCD centiseconds, seconds and minutes (MM:SS.CC) for the display mux stage. Each rising edge of the base tick is one 10 ms increment.

---
 rtl/stopwatch_bcd_counter.sv | 152 +++++++++++++++
 tb/tb_stopwatch_bcd_counter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd_counter.sv
// MM:SS.CC BCD stopwatch with run/pause/clear control of the 10 ms base timer.
// Define LAP_HOLD_EN to add the lap-hold display freeze (i_lap / o_lap_active).
module stopwatch_bcd_counter #(
    parameter int MIN_TENS_MAX = 5
) (
    input  logic       i_sclk,
    input  logic       i_reset_n,
    input  logic       i_base_tick,
    input  logic       i_start_stop,
    input  logic       i_clear,
`ifdef LAP_HOLD_EN
    input  logic       i_lap,
    output logic       o_lap_active,
`endif
    output logic       o_timerenb,
    output logic       o_timer_rst_n,
    output logic [3:0] o_cs_ones,
    output logic [3:0] o_cs_tens,
    output logic [3:0] o_s_ones,
    output logic [3:0] o_s_tens,
    output logic [3:0] o_m_ones,
    output logic [3:0] o_m_tens,
    output logic       o_rollover,
    output logic       o_running
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [3:0] M_TENS_MAX = 4'(MIN_TENS_MAX);
    // Digit order, least significant first: cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens
    localparam logic [5:0][3:0] DIG_MAX = {M_TENS_MAX, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] dmax);
        return (d == dmax) ? 4'd0 : d + 4'd1;
    endfunction

    logic [1:0]      state_q, state_d;
    logic            tick_q, ss_q, clr_q;
    logic            tick_ev, ss_ev, clr_ev;
    logic            clear_act;
    logic            carry, wrap;
    logic [5:0][3:0] dig_q, dig_d;
    logic [5:0][3:0] disp;
    logic            rollover_q;
    logic            timer_rst_n_q;

    assign tick_ev = i_base_tick  & ~tick_q;
    assign ss_ev   = i_start_stop & ~ss_q;
    assign clr_ev  = i_clear      & ~clr_q;

    // Clear beats start outside RUN; inside RUN start/stop beats (and drops) clear.
    always_comb begin
        state_d   = state_q;
        clear_act = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_ev)     clear_act = 1'b1;
                else if (ss_ev) state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (ss_ev) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (clr_ev) begin
                    clear_act = 1'b1;
                    state_d   = ST_IDLE;
                end else if (ss_ev) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dig_d = dig_q;
        carry = (state_q == ST_RUN) && tick_ev;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                dig_d[i] = bcd_inc(dig_q[i], DIG_MAX[i]);
                carry    = (dig_q[i] == DIG_MAX[i]);
            end
        end
        wrap = carry;
        if (clear_act) dig_d = '0;
    end

    always_ff @(posedge i_sclk) begin
        if (!i_reset_n) begin
            state_q       <= ST_IDLE;
            tick_q        <= 1'b0;
            ss_q          <= 1'b0;
            clr_q         <= 1'b0;
            dig_q         <= '0;
            rollover_q    <= 1'b0;
            timer_rst_n_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            tick_q        <= i_base_tick;
            ss_q          <= i_start_stop;
            clr_q         <= i_clear;
            dig_q         <= dig_d;
            rollover_q    <= wrap;
            timer_rst_n_q <= ~clear_act;
        end
    end

`ifdef LAP_HOLD_EN
    logic            lap_q, lap_active_q, lap_ev;
    logic [5:0][3:0] hold_q;

    assign lap_ev = i_lap & ~lap_q;

    always_ff @(posedge i_sclk) begin
        if (!i_reset_n) begin
            lap_q        <= 1'b0;
            lap_active_q <= 1'b0;
        end else begin
            lap_q <= i_lap;
            if (clear_act || (lap_ev && lap_active_q))
                lap_active_q <= 1'b0;
            else if (lap_ev && (state_q == ST_RUN))
                lap_active_q <= 1'b1;
        end
    end

    // Snapshot is data only; its validity is carried by lap_active_q.
    always_ff @(posedge i_sclk) begin
        if (lap_ev && !lap_active_q && (state_q == ST_RUN))
            hold_q <= dig_q;
    end

    assign disp         = lap_active_q ? hold_q : dig_q;
    assign o_lap_active = lap_active_q;
`else
    assign disp = dig_q;
`endif

    assign o_cs_ones     = disp[0];
    assign o_cs_tens     = disp[1];
    assign o_s_ones      = disp[2];
    assign o_s_tens      = disp[3];
    assign o_m_ones      = disp[4];
    assign o_m_tens      = disp[5];
    assign o_running     = (state_q == ST_RUN);
    assign o_timerenb    = (state_q == ST_RUN);
    assign o_rollover    = rollover_q;
    assign o_timer_rst_n = timer_rst_n_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Scoreboard bench for stopwatch_bcd_counter: directed scenarios plus random stimulus
// against an elapsed-centiseconds reference model.
module tb_stopwatch_bcd_counter;

    localparam int MT     = 1;
    localparam int PERIOD = (MT + 1) * 60000;

    logic clk = 1'b0;
    logic reset_n = 1'b0, base_tick = 1'b0, start_stop = 1'b0, clear = 1'b0;
    logic lap = 1'b0;
    logic lap_active;
    logic timerenb, timer_rst_n, rollover, running;
    logic [3:0] cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens;

    always #5 clk = ~clk;

    stopwatch_bcd_counter #(.MIN_TENS_MAX(MT)) dut (
        .i_sclk        (clk),
        .i_reset_n     (reset_n),
        .i_base_tick   (base_tick),
        .i_start_stop  (start_stop),
        .i_clear       (clear),
`ifdef LAP_HOLD_EN
        .i_lap         (lap),
        .o_lap_active  (lap_active),
`endif
        .o_timerenb    (timerenb),
        .o_timer_rst_n (timer_rst_n),
        .o_cs_ones     (cs_ones),
        .o_cs_tens     (cs_tens),
        .o_s_ones      (s_ones),
        .o_s_tens      (s_tens),
        .o_m_ones      (m_ones),
        .o_m_tens      (m_tens),
        .o_rollover    (rollover),
        .o_running     (running)
    );

    typedef struct packed {
        logic        run;
        logic        enb;
        logic        trn;
        logic        roll;
        logic [23:0] dig;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: elapsed centiseconds plus a named mode (0 idle, 1 run, 2 pause)
    int count = 0;
    int mode  = 0;
    bit ptick = 0, pss = 0, pclr = 0;

    task automatic drive(input logic rn, input logic tk, input logic ss, input logic cl);
        exp_t e;
        bit   tev, sev, cev, roll, trn;
        int   m, s, cs;
        @(negedge clk);
        reset_n = rn; base_tick = tk; start_stop = ss; clear = cl;
        roll = 0; trn = 1;
        if (!rn) begin
            count = 0; mode = 0; ptick = 0; pss = 0; pclr = 0;
        end else begin
            tev = tk && !ptick; sev = ss && !pss; cev = cl && !pclr;
            if (mode == 1) begin
                if (tev) begin
                    count = count + 1;
                    if (count == PERIOD) begin count = 0; roll = 1; end
                end
                if (sev) mode = 2;
            end else if (cev) begin
                count = 0; mode = 0; trn = 0;
            end else if (sev) begin
                mode = 1;
            end
            ptick = tk; pss = ss; pclr = cl;
        end
        cs = count % 100;
        s  = (count / 100) % 60;
        m  = count / 6000;
        e.run  = (mode == 1);
        e.enb  = (mode == 1);
        e.trn  = trn;
        e.roll = roll;
        e.dig  = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
        q.push_back(e);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, 1, 0, 0);
            drive(1, 0, 0, 0);
        end
    endtask

    task automatic press_ss();
        drive(1, 0, 1, 0);
        drive(1, 0, 0, 0);
    endtask

    task automatic press_clr();
        drive(1, 0, 0, 1);
        drive(1, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
        end
    endtask

    exp_t me;
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("running",     {23'd0, running},     {23'd0, me.run});
            chk("timerenb",    {23'd0, timerenb},    {23'd0, me.enb});
            chk("timer_rst_n", {23'd0, timer_rst_n}, {23'd0, me.trn});
            chk("rollover",    {23'd0, rollover},    {23'd0, me.roll});
            chk("digits", {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones}, me.dig);
        end
    end

    initial begin
        logic tk, ss, cl, rn;
        repeat (3) drive(0, 0, 0, 0);
        // start, 10 ticks, then on to .42 and pause/resume
        press_ss();
        ticks(10);
        ticks(32);
        press_ss();
        ticks(5);
        press_ss();
        ticks(1);
        // reach 00:01.00, clear ignored in RUN, then pause + clear
        ticks(57);
        press_clr();
        press_ss();
        press_clr();
        // start/stop together with clear in PAUSE
        press_ss();
        ticks(3);
        press_ss();
        drive(1, 0, 1, 1);
        drive(1, 0, 0, 0);
        // simultaneous in RUN: pause wins, clear dropped
        press_ss();
        ticks(2);
        drive(1, 0, 1, 1);
        drive(1, 0, 0, 0);
        press_clr();
        // held start/stop from IDLE with ticks running
        for (int i = 0; i < 1000; i++) drive(1, logic'(i % 2), 1, 0);
        drive(1, 0, 0, 0);
        press_ss();
        press_clr();
        // full period through 00:59.99 -> 01:00.00 and full wrap
        press_ss();
        ticks(PERIOD + 5);
        press_ss();
        press_clr();
        // random phase
        tk = 0; ss = 0; cl = 0;
        for (int i = 0; i < 20000; i++) begin
            tk = logic'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) ss = ~ss;
            if ($urandom_range(0, 59) == 0) cl = ~cl;
            rn = ($urandom_range(0, 999) != 0);
            drive(rn, tk, ss, cl);
        end
        drive(1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
